// File: rtl/ets_accum_multi_if.sv
// ets_accum_multi_if: start/abort/window control, per-channel samples,
// and busy/done/count/overflow results for ets_accum_multi.
interface ets_accum_multi_if #(
  parameter int CH = 4,
  parameter int DW = 16,
  parameter int WW = 32
);
  logic [WW-1:0]    window;
  logic [CH-1:0]    data_in;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [CH*DW-1:0] data;
  logic [CH-1:0]    ovf;

  modport master (
    output window, data_in, start, abort,
    input  busy, done, data, ovf
  );

  modport slave (
    input  window, data_in, start, abort,
    output busy, done, data, ovf
  );
endinterface

// File: rtl/ets_accum_multi.sv
// ets_accum_multi: windowed per-channel hit counters (IDLE/BUSY/DONE/CLR).
// ETS_ACCUM_SAT_EN selects saturating counters; default wraps.
module ets_accum_multi #(
  parameter int CH = 4,
  parameter int DW = 16,
  parameter int WW = 32
) (
  input logic            clk,
  input logic            rst_n,
  ets_accum_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    CLR  = 2'd3
  } state_t;

  localparam int NSEG = (DW + 7) / 8;
  localparam int PW   = NSEG * 8;

  state_t          state_q, state_d;
  logic [WW-1:0]   win_q;
  logic [WW-1:0]   cyc_q;
  logic [CH*DW-1:0] data_w;
  logic [CH-1:0]   ovf_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.window == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.abort) begin
          state_d = CLR;
        end else if (cyc_q + WW'(1) == win_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.start) begin
          state_d = CLR;
        end
      end
      CLR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      cyc_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            win_q <= bus.window;
            cyc_q <= '0;
          end
        end
        BUSY:    cyc_q <= cyc_q + WW'(1);
        CLR:     cyc_q <= '0;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] pc, pn;
    logic          hit, full, c;

    assign hit  = (state_q == BUSY) && !bus.abort && bus.data_in[i];
    assign full = hit && (&cnt_q);

    // 8-bit segments; a segment steps only when all lower ones roll over
    always_comb begin
      pc = '0;
      pc[DW-1:0] = cnt_q;
      pn = pc;
      c = hit;
      for (int s = 0; s < NSEG; s++) begin
        pn[s*8 +: 8] = pc[s*8 +: 8] + {7'b0, c};
        c = c & (&pc[s*8 +: 8]);
      end
`ifdef ETS_ACCUM_SAT_EN
      cnt_d = full ? cnt_q : pn[DW-1:0];
`else
      cnt_d = pn[DW-1:0];
`endif
      ovf_d = ovf_q | full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == CLR) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign data_w[i*DW +: DW] = cnt_q;
    assign ovf_w[i]           = ovf_q;
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.done = (state_q == DONE);
  assign bus.data = data_w;
  assign bus.ovf  = ovf_w;

endmodule

// File: tb/tb_ets_accum_multi.sv
// tb_ets_accum_multi: drives DW=16 and DW=8 instances in lockstep and
// compares against per-channel hit totals kept by the bench.
module tb_ets_accum_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] window;
  logic [3:0]  data_in;
  logic        start;
  logic        abort;

  int n_chk  = 0;
  int n_fail = 0;
  int hits [4];

  ets_accum_multi_if #(.CH(4), .DW(16), .WW(32)) b16 ();
  ets_accum_multi_if #(.CH(4), .DW(8),  .WW(32)) b8 ();

  assign b16.window  = window;
  assign b16.data_in = data_in;
  assign b16.start   = start;
  assign b16.abort   = abort;
  assign b8.window   = window;
  assign b8.data_in  = data_in;
  assign b8.start    = start;
  assign b8.abort    = abort;

  ets_accum_multi #(.CH(4), .DW(16), .WW(32)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  ets_accum_multi #(.CH(4), .DW(8), .WW(32)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int h, input int dw);
    int mx;
    mx = (1 << dw) - 1;
`ifdef ETS_ACCUM_SAT_EN
    return (h > mx) ? 64'(mx) : 64'(h);
`else
    return 64'(h % (mx + 1));
`endif
  endfunction

  function automatic logic [63:0] exp_ovf(input int dw);
    logic [63:0] o;
    o = '0;
    for (int ch = 0; ch < 4; ch++) o[ch] = hits[ch] > ((1 << dw) - 1);
    return o;
  endfunction

  task automatic chk_data(input string tag);
    for (int ch = 0; ch < 4; ch++) begin
      chk($sformatf("%s_d16_ch%0d", tag, ch),
          64'(b16.data[ch*16 +: 16]), exp_cnt(hits[ch], 16));
      chk($sformatf("%s_d8_ch%0d", tag, ch),
          64'(b8.data[ch*8 +: 8]), exp_cnt(hits[ch], 8));
    end
    chk({tag, "_ovf16"}, 64'(b16.ovf), exp_ovf(16));
    chk({tag, "_ovf8"}, 64'(b8.ovf), exp_ovf(8));
  endtask

  task automatic chk_st(input string tag, input logic bz, input logic dn);
    chk({tag, "_busy16"}, 64'(b16.busy), 64'(bz));
    chk({tag, "_done16"}, 64'(b16.done), 64'(dn));
    chk({tag, "_busy8"}, 64'(b8.busy), 64'(bz));
    chk({tag, "_done8"}, 64'(b8.done), 64'(dn));
  endtask

  function automatic logic [3:0] gen(input int mode, input int c);
    unique case (mode)
      0: return 4'b0101;
      1: return {2'b00, c[0], 1'b0};
      2: return 4'($urandom);
      default: return 4'hF;
    endcase
  endfunction

  // Full start/run/ack sequence; abort_at / chg_at of 0 disable those events
  task automatic do_run(input string tag, input int w, input int mode,
                        input int abort_at, input int chg_at);
    bit aborted;
    aborted = 0;
    for (int ch = 0; ch < 4; ch++) hits[ch] = 0;
    window  = 32'(w);
    start   = 1'b1;
    abort   = 1'b0;
    data_in = gen(mode, 0);
    @(posedge clk);
    #1;
    if (w == 0) begin
      chk_st({tag, "_w0"}, 1'b0, 1'b1);
      chk_data({tag, "_w0"});
    end else begin
      chk_st({tag, "_go"}, 1'b1, 1'b0);
      for (int c = 1; c <= w; c++) begin
        data_in = gen(mode, c);
        if (c == abort_at) abort = 1'b1;
        if (c == chg_at) window = 32'd5;
        @(posedge clk);
        if (abort) begin
          aborted = 1;
          #1;
          abort = 1'b0;
          chk_st({tag, "_clr"}, 1'b0, 1'b0);
          break;
        end
        for (int ch = 0; ch < 4; ch++) hits[ch] += int'(data_in[ch]);
        #1;
        if (c < w) begin
          if (c == 1 || c == w - 1) chk_st({tag, "_run"}, 1'b1, 1'b0);
        end else begin
          chk_st({tag, "_end"}, 1'b0, 1'b1);
          chk_data({tag, "_end"});
        end
      end
    end
    if (aborted) begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 4; ch++) hits[ch] = 0;
      chk_st({tag, "_idle"}, 1'b0, 1'b0);
      chk_data({tag, "_idle"});
      start = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    data_in = gen(2, 0);
    @(posedge clk);
    #1;
    chk_st({tag, "_hold"}, 1'b0, 1'b1);
    chk_data({tag, "_hold"});
    start = 1'b0;
    @(posedge clk);
    #1;
    chk_st({tag, "_ack"}, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 4; ch++) hits[ch] = 0;
    chk_st({tag, "_cleared"}, 1'b0, 1'b0);
    chk_data({tag, "_cleared"});
  endtask

  initial begin
    rst_n   = 1'b0;
    window  = '0;
    data_in = '0;
    start   = 1'b0;
    abort   = 1'b0;
    for (int ch = 0; ch < 4; ch++) hits[ch] = 0;
    #12;
    chk_st("reset", 1'b0, 1'b0);
    chk_data("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_run("const10", 10, 0, 0, 0);
    do_run("win0", 0, 0, 0, 0);
    do_run("tog1000", 1000, 1, 0, 37);
    do_run("abort3", 20, 3, 3, 0);
    do_run("ones300", 300, 3, 0, 0);
    for (int k = 0; k < 6; k++) begin
      do_run("rand", int'($urandom_range(1, 40)), 2, 0, 0);
    end
    do_run("win1", 1, 3, 0, 0);

    window  = 32'd20;
    data_in = 4'hF;
    start   = 1'b1;
    for (int c = 0; c < 5; c++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int ch = 0; ch < 4; ch++) hits[ch] = 0;
    chk_st("async_rst", 1'b0, 1'b0);
    chk_data("async_rst");
    #1;
    rst_n = 1'b1;
    do_run("post_rst", 20, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
